// File: rtl/audio_pkg.sv
// Shared constants, slot encoding and sample-format helper for the I2S transmitter.
package audio_pkg;

    localparam int FRAME_BITS      = 64;
    localparam int SLOT_BITS       = 32;
    localparam int DATA_BITS       = 16;
    localparam int DATA_SLOT_FIRST = 1;
    localparam int BIT_CNT_W       = $clog2(FRAME_BITS);

    typedef enum logic {
        SLOT_LEFT  = 1'b0,
        SLOT_RIGHT = 1'b1
    } slot_e;

    // Offset-binary 12-bit mixer output to left-justified two's complement.
    function automatic logic [DATA_BITS-1:0] fmt_unsigned12(input logic [11:0] s);
        return {~s[11], s[10:0], 4'b0000};
    endfunction

endpackage

// File: rtl/audio_i2s_tx_if.sv
// Sample stream between the mixer (master) and the I2S transmitter (slave).
interface audio_i2s_tx_if;
    import audio_pkg::*;

    logic [DATA_BITS-1:0] sample_in;
    logic                 sample_valid;
    logic                 sample_ready;
    logic                 mute;
    logic                 frame_tick;
    logic                 underrun;

    modport master (
        output sample_in, sample_valid, mute,
        input  sample_ready, frame_tick, underrun
    );

    modport slave (
        input  sample_in, sample_valid, mute,
        output sample_ready, frame_tick, underrun
    );

endinterface

// File: rtl/i2s_clk_div.sv
// Bit-clock divider: generates BCLK, a strobe on each BCLK falling toggle and the frame bit counter.
module i2s_clk_div
    import audio_pkg::*;
#(
    parameter int BCLK_HALF = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 bclk,
    output logic                 fall_evt,
    output logic [BIT_CNT_W-1:0] bit_cnt
);

    logic [7:0]           div_cnt_q, div_cnt_d;
    logic                 bclk_q, bclk_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic                 toggle;

    always_comb begin
        toggle    = (div_cnt_q == 8'(BCLK_HALF - 1));
        div_cnt_d = toggle ? 8'd0 : div_cnt_q + 8'd1;
        bclk_d    = toggle ? ~bclk_q : bclk_q;
        fall_evt  = toggle && bclk_q;
        bit_cnt_d = fall_evt ? bit_cnt_q + 1'b1 : bit_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
            bit_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign bclk    = bclk_q;
    assign bit_cnt = bit_cnt_q;

endmodule

// File: rtl/audio_i2s_tx.sv
// Mono I2S master: one-entry sample hold, format conversion, and serialisation of the
// same sample into both slots of each 64-bit frame.
module audio_i2s_tx
    import audio_pkg::*;
#(
    parameter int BCLK_HALF   = 8,
    parameter bit UNSIGNED_IN = 1'b1
) (
    input  logic           CLOCK_50,
    input  logic           reset,
    audio_i2s_tx_if.slave  bus,
    output logic           AUD_BCLK,
    output logic           AUD_DACLRCK,
    output logic           AUD_DACDAT
);

    logic                 fall_evt;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [BIT_CNT_W-1:0] n;
    logic [4:0]           slot_pos;
    logic [3:0]           bit_idx;
    logic                 load_evt, bypass, accept;
    logic [DATA_BITS-1:0] fmt_in;

    logic                 hold_full_q, hold_full_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    slot_e                lrck_q, lrck_d;
    logic                 dat_q, dat_d;
    logic                 tick_q, tick_d;
    logic                 underrun_q, underrun_d;

    i2s_clk_div #(.BCLK_HALF(BCLK_HALF)) u_clk_div (
        .clk      (CLOCK_50),
        .rst      (reset),
        .bclk     (AUD_BCLK),
        .fall_evt (fall_evt),
        .bit_cnt  (bit_cnt)
    );

    generate
        if (UNSIGNED_IN) begin : g_unsigned
            logic unused_hi_bits;
            assign fmt_in         = fmt_unsigned12(bus.sample_in[11:0]);
            assign unused_hi_bits = ^bus.sample_in[15:12];
        end else begin : g_signed
            assign fmt_in = bus.sample_in;
        end
    endgenerate

    always_comb begin
        hold_full_d = hold_full_q;
        hold_d      = hold_q;
        shift_d     = shift_q;
        lrck_d      = lrck_q;
        dat_d       = dat_q;
        underrun_d  = 1'b0;

        n        = bit_cnt + 1'b1;
        slot_pos = n[4:0];
        bit_idx  = 4'(5'(DATA_BITS) - slot_pos);

        load_evt = fall_evt && (n == '0);
        tick_d   = load_evt;
        bypass   = load_evt && !bus.mute && !hold_full_q && bus.sample_valid;
        accept   = bus.sample_valid && !hold_full_q && !bypass;

        // One-BCLK I2S delay: slot bit 0 is always zero, data occupies bits 1..16.
        if (fall_evt) begin
            lrck_d = slot_e'(n[BIT_CNT_W-1]);
            if (slot_pos >= 5'(DATA_SLOT_FIRST) && slot_pos <= 5'(DATA_BITS))
                dat_d = shift_q[bit_idx];
            else
                dat_d = 1'b0;
        end

        // Mute wins but still drains the hold so the source is not stalled.
        if (load_evt) begin
            if (bus.mute) begin
                shift_d     = '0;
                hold_full_d = 1'b0;
            end else if (hold_full_q) begin
                shift_d     = hold_q;
                hold_full_d = 1'b0;
            end else if (bypass) begin
                shift_d = fmt_in;
            end else begin
                underrun_d = 1'b1;
            end
        end

        if (accept) begin
            hold_d      = fmt_in;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            hold_full_q <= 1'b0;
            hold_q      <= '0;
            shift_q     <= '0;
            lrck_q      <= SLOT_LEFT;
            dat_q       <= 1'b0;
            tick_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            hold_full_q <= hold_full_d;
            hold_q      <= hold_d;
            shift_q     <= shift_d;
            lrck_q      <= lrck_d;
            dat_q       <= dat_d;
            tick_q      <= tick_d;
            underrun_q  <= underrun_d;
        end
    end

    assign AUD_DACLRCK      = lrck_q;
    assign AUD_DACDAT       = dat_q;
    assign bus.sample_ready = !hold_full_q;
    assign bus.frame_tick   = tick_q;
    assign bus.underrun     = underrun_q;

endmodule

// File: doc/audio_i2s_tx.md
Name: audio_i2s_tx

Overview:
- Mono I2S master transmitter. Sits between the synthesizer mixer output and the board audio codec DAC input (AUD_BCLK / AUD_DACLRCK / AUD_DACDAT).
- Accepts 16-bit samples through a valid/ready handshake into a one-entry holding register. Converts the mixer's unsigned 12-bit format to signed 16-bit.
- Serializes the same sample on the left and right slots of each 64-bit I2S frame.

Parameters:
- BCLK_HALF, 8, CLOCK_50 cycles per BCLK half-period (BCLK = 3.125 MHz; frame = 64 BCLK = 1024 cycles ≈ 48.83 kHz); legal range 2..255.
- UNSIGNED_IN, 1, 1 = sample_in[11:0] is unsigned 0..4095 and is converted; 0 = sample_in is already signed 16-bit.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- sample_in  in  16  sample from the mixer.
- sample_valid  in  1  sample_in is valid this cycle.
- sample_ready  out  1  holding register is empty; the sample is accepted when valid && ready.
- mute  in  1  when set, forces zero data into the frame loaded on the next load event.
- frame_tick  out  1  one-cycle pulse on each frame load event.
- underrun  out  1  one-cycle pulse on a frame load with no new sample.
- AUD_BCLK  out  1  bit clock.
- AUD_DACLRCK  out  1  0 = left slot, 1 = right slot.
- AUD_DACDAT  out  1  serial data, MSB first.

Behaviour:
- Reset values: AUD_BCLK=0, AUD_DACLRCK=0, AUD_DACDAT=0, frame_tick=0, underrun=0, sample_ready=1.
- Internal reset values: div_cnt=0, bit_cnt=0, hold_full=0, shift_data=0.
- Reset asserted mid-frame aborts immediately. After release, the first frame is silent; the first real load happens on the 63→0 wrap.
- Divider:
  - div_cnt counts 0..BCLK_HALF-1.
  - On the wrap cycle ("toggle event"), AUD_BCLK inverts.
  - A toggle event with AUD_BCLK==1 is a "falling event".
- Falling event:
  - bit_cnt <= bit_cnt+1 mod 64, with n = new bit_cnt.
  - AUD_DACLRCK <= n[5].
  - Let s = n[4:0]. AUD_DACDAT <= shift_data[16-s] for s in 1..16, else 0 (I2S one-BCLK delay; slots 17..31 are zero).
  - All outputs change only on falling events, so they are stable on every BCLK rising edge.
- Load event: the falling event where n==0, one per frame. In the same cycle:
  - frame_tick=1.
  - If mute, shift_data <= 0.
  - Else if hold_full, shift_data <= fmt(hold) and hold_full <= 0.
  - Else if sample_valid && sample_ready, bypass: shift_data <= fmt(sample_in); the sample is not stored in hold.
  - Else shift_data is unchanged (last sample repeats) and underrun=1.
  - mute has priority. A held sample is still consumed under mute, and underrun is not asserted.
- The bit driven at n==0 (slot 0) uses the zero rule, so the newly loaded data first appears at n==1.
- Handshake:
  - sample_ready = !hold_full (registered state, no combinational path from sample_valid).
  - Accept outside the load bypass: hold <= sample_in, hold_full <= 1.
  - A sample_valid arriving while hold_full is ignored; the source must hold it until ready.
- fmt():
  - UNSIGNED_IN=1: {~s[11], s[10:0], 4'b0000}, where s = sample_in[11:0]. Maps 0 → 0x8000, 2048 → 0x0000, 4095 → 0x7FF0.
  - UNSIGNED_IN=0: identity.
- Sample_valid held high continuously: one accept per frame. Ready stays low until the next load event.

Decomposition:
- Package audio_pkg: FRAME_BITS=64, SLOT_BITS=32, DATA_BITS=16, DATA_SLOT_FIRST=1, function fmt_unsigned12.
- One sub-module, i2s_clk_div: parameter BCLK_HALF; outputs AUD_BCLK, a falling-event strobe and bit_cnt. The top level holds the handshake, holding register, shift logic and flags.

Test Plan:
- Reset, then release with no samples: AUD_DACDAT stays 0 for the first frame. AUD_BCLK period = 16 cycles. AUD_DACLRCK toggles every 512 cycles. underrun pulses at the first load (cycle 1024 after release).
- Offer sample_in=0x0FFF once, before the load: AUD_DACDAT sequence in left slots 1..16 = 0x7FF0 MSB first, then zeros. The right slot is identical. frame_tick and sample_ready rise back to 1 in the load cycle.
- sample_valid arriving exactly on the load cycle with hold empty, value 0x0000: bypass loads 0x8000. Slot 1 = 1, slots 2..16 = 0. No underrun. hold_full stays 0.
- Two samples 0x0800 then 0x0001, back-to-back: the first is accepted and sample_ready drops. The second is stalled until the load. Frame k carries 0x0000, frame k+1 carries 0x8010.
- mute=1 with hold_full: frame data all zero. hold_full clears. underrun=0.
- Assert reset mid-right-slot: all outputs return to reset values within the reset cycle. After release, timing restarts with bit_cnt=0.
